// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state type and constants for the clock divider controller
package clk_div_pkg;
  typedef enum logic [1:0] {STOP, RUN, PEND} state_t;
  localparam int MIN_DIV = 2;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: divide-ratio reconfiguration handshake
interface clk_div_ctrl_if import clk_div_pkg::*; #(parameter int CNT_W = DEF_CNT_W);
  logic cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic cfg_ready;
  logic cfg_err;
  modport master (output cfg_valid, cfg_div, input cfg_ready, cfg_err);
  modport slave (input cfg_valid, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_core.sv
// clk_div_core: period counter with tick and divided-waveform decode
module clk_div_core #(parameter int CNT_W = 8) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  input  logic [CNT_W-1:0] cur_div,
  output logic tick,
  output logic div_out
);
  logic [CNT_W-1:0] cnt;
  logic last;
  assign last = cnt == cur_div - CNT_W'(1);
  always_ff @(posedge clk)
    if (!rst || clear) cnt <= '0;
    else if (run) cnt <= last ? '0 : cnt + CNT_W'(1);
  assign tick = run && last;
  assign div_out = run && (cnt < (cur_div >> 1));
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: start/stop and ratio sequencer for a clock-enable divider; CLK_DIV_CTRL_TICK_CNT_EN adds tick_cnt
module clk_div_ctrl import clk_div_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEF_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  clk_div_ctrl_if.slave cfg,
  output logic tick,
  output logic div_out,
  output logic busy
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  , output logic [15:0] tick_cnt
`endif
);
  state_t state, state_n;
  logic [CNT_W-1:0] cur_div, cur_div_n, pend_div, pend_div_n;
  logic take, halt;
  assign busy = state != STOP;
  assign halt = busy && stop;
  assign cfg.cfg_ready = state != PEND;
  assign take = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_div >= CNT_W'(MIN_DIV));
  always_ff @(posedge clk)
    if (!rst) begin
      state <= STOP;
      cur_div <= CNT_W'(DEF_DIV);
      pend_div <= '0;
      cfg.cfg_err <= 1'b0;
    end else begin
      state <= state_n;
      cur_div <= cur_div_n;
      pend_div <= pend_div_n;
      cfg.cfg_err <= cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_div < CNT_W'(MIN_DIV));
    end
  // stop commits any pending ratio; otherwise a ratio taken while stopping lands directly
  always_comb begin
    state_n = state;
    cur_div_n = cur_div;
    pend_div_n = pend_div;
    if (state == STOP) begin
      if (take) cur_div_n = cfg.cfg_div;
      if (start) state_n = RUN;
    end else if (halt) begin
      state_n = STOP;
      cur_div_n = state == PEND ? pend_div : take ? cfg.cfg_div : cur_div;
    end else if (state == PEND) begin
      if (tick) begin
        cur_div_n = pend_div;
        state_n = RUN;
      end
    end else if (take) begin
      pend_div_n = cfg.cfg_div;
      state_n = PEND;
    end
  end
  clk_div_core #(.CNT_W(CNT_W)) core (
    .clk(clk),
    .rst(rst),
    .run(busy),
    .clear(halt),
    .cur_div(cur_div),
    .tick(tick),
    .div_out(div_out)
  );
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  always_ff @(posedge clk)
    if (!rst || (state == STOP && start)) tick_cnt <= '0;
    else if (tick && tick_cnt != 16'hFFFF) tick_cnt <= tick_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed plus random stimulus against a period-level reference model
module tb_clk_div_ctrl;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic tick, div_out, busy;
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  logic [15:0] tick_cnt;
`endif
  int checks = 0;
  int errors = 0;
  bit m_run, m_pend, m_err;
  int m_div, m_pdiv, m_ph, m_tc;

  clk_div_ctrl_if #(.CNT_W(W)) cfg ();

  clk_div_ctrl #(.CNT_W(W), .DEF_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .cfg(cfg),
    .tick(tick),
    .div_out(div_out),
    .busy(busy)
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    , .tick_cnt(tick_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic cmp(string tag, logic [15:0] got, logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Model: m_ph is the position inside the current period, m_div the period length
  task automatic model(bit r, bit s, bit p, bit v, int d);
    bit acc, legal, bnd;
    acc = v && !m_pend;
    legal = d >= 2;
    bnd = m_run && (m_ph == m_div - 1);
    if (!r) begin
      m_run = 0; m_pend = 0; m_err = 0;
      m_div = 4; m_pdiv = 0; m_ph = 0; m_tc = 0;
      return;
    end
    m_err = acc && !legal;
    if (bnd && m_tc < 65535) m_tc++;
    if (!m_run) begin
      if (acc && legal) m_div = d;
      if (s) begin m_run = 1; m_ph = 0; m_tc = 0; end
    end else if (p) begin
      if (m_pend) m_div = m_pdiv;
      else if (acc && legal) m_div = d;
      m_run = 0; m_pend = 0; m_ph = 0;
    end else begin
      m_ph = bnd ? 0 : m_ph + 1;
      if (m_pend && bnd) begin m_div = m_pdiv; m_pend = 0; end
      else if (acc && legal) begin m_pend = 1; m_pdiv = d; end
    end
  endtask

  task automatic check(string tag);
    cmp({tag, ".busy"}, 16'(busy), 16'(m_run));
    cmp({tag, ".tick"}, 16'(tick), 16'(m_run && (m_ph == m_div - 1)));
    cmp({tag, ".div_out"}, 16'(div_out), 16'(m_run && (m_ph < m_div / 2)));
    cmp({tag, ".cfg_ready"}, 16'(cfg.cfg_ready), 16'(!m_pend));
    cmp({tag, ".cfg_err"}, 16'(cfg.cfg_err), 16'(m_err));
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    cmp({tag, ".tick_cnt"}, tick_cnt, 16'(m_tc));
`endif
  endtask

  task automatic step(bit r, bit s, bit p, bit v, int d, string tag);
    rst = r;
    start = s;
    stop = p;
    cfg.cfg_valid = v;
    cfg.cfg_div = W'(d);
    model(r, s, p, v, d);
    @(posedge clk);
    @(negedge clk);
    check(tag);
  endtask

  task automatic idle(int n, string tag);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, $urandom_range(0, 255), tag);
  endtask

  initial begin
    bit r, s, p, v;
    int d;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_div = '0;
    step(0, 0, 0, 0, 0, "reset");
    step(0, 0, 0, 0, 0, "reset");
    cmp("reset_ready", 16'(cfg.cfg_ready), 16'd1);
    cmp("reset_busy", 16'(busy), 16'd0);
    // 1: default ratio 4
    step(1, 1, 0, 0, 0, "t1_start");
    for (int i = 0; i < 8; i++) begin
      if (i > 0) idle(1, "t1");
      cmp("t1_div_out", 16'(div_out), 16'(i % 4 < 2));
      cmp("t1_tick", 16'(tick), 16'(i % 4 == 3));
    end
    // 2: new ratio 6 accepted mid-period
    idle(1, "t2_pre");
    step(1, 0, 0, 1, 6, "t2_acc");
    cmp("t2_ready_low", 16'(cfg.cfg_ready), 16'd0);
    idle(2, "t2_finish4");
    cmp("t2_old_tick", 16'(tick), 16'd1);
    for (int i = 0; i < 12; i++) begin
      idle(1, "t2");
      cmp("t2_div_out", 16'(div_out), 16'(i % 6 < 3));
      cmp("t2_tick", 16'(tick), 16'(i % 6 == 5));
    end
    cmp("t2_ready_back", 16'(cfg.cfg_ready), 16'd1);
    // 3: illegal ratios
    step(1, 0, 0, 1, 1, "t3_one");
    cmp("t3_err1", 16'(cfg.cfg_err), 16'd1);
    step(1, 0, 0, 1, 0, "t3_zero");
    cmp("t3_err0", 16'(cfg.cfg_err), 16'd1);
    idle(1, "t3_after");
    cmp("t3_err_clear", 16'(cfg.cfg_err), 16'd0);
    idle(8, "t3_run");
    // 4: stop beats start; stop in PEND commits pending ratio
    step(1, 1, 1, 0, 0, "t4_both");
    cmp("t4_busy", 16'(busy), 16'd0);
    cmp("t4_tick", 16'(tick), 16'd0);
    cmp("t4_div_out", 16'(div_out), 16'd0);
    step(1, 1, 0, 0, 0, "t4_start");
    idle(1, "t4");
    step(1, 0, 0, 1, 5, "t4_acc5");
    step(1, 0, 1, 0, 0, "t4_stop");
    step(1, 1, 0, 0, 0, "t4_restart");
    for (int i = 0; i < 10; i++) begin
      if (i > 0) idle(1, "t4");
      cmp("t4_div_out5", 16'(div_out), 16'(i % 5 < 2));
      cmp("t4_tick5", 16'(tick), 16'(i % 5 == 4));
    end
    // 5: reset during PEND
    step(1, 0, 0, 1, 7, "t5_acc7");
    step(0, 0, 0, 0, 0, "t5_rst");
    cmp("t5_busy", 16'(busy), 16'd0);
    cmp("t5_ready", 16'(cfg.cfg_ready), 16'd1);
    step(1, 1, 0, 0, 0, "t5_start");
    for (int i = 0; i < 8; i++) begin
      if (i > 0) idle(1, "t5");
      cmp("t5_div_out", 16'(div_out), 16'(i % 4 < 2));
      cmp("t5_tick", 16'(tick), 16'(i % 4 == 3));
    end
    // 6: maximum ratio 255
    step(1, 0, 1, 0, 0, "t6_stop");
    step(1, 0, 0, 1, 255, "t6_acc");
    step(1, 1, 0, 0, 0, "t6_start");
    for (int i = 0; i < 520; i++) begin
      if (i > 0) idle(1, "t6");
      if (i % 255 >= 253) cmp("t6_tick", 16'(tick), 16'(i % 255 == 254));
    end
    step(1, 0, 1, 0, 0, "t6_stop2");
    step(1, 1, 0, 0, 0, "t6_restart");
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 199) != 0;
      s = $urandom_range(0, 19) == 0;
      p = !s && ($urandom_range(0, 29) == 0);
      v = $urandom_range(0, 5) == 0;
      d = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 12));
      step(r, s, p, v, d, "rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
